// File: rtl/rgb_pwm_fader.sv
// Multi-channel LED PWM driver with off/static/breathe/blink modes.
// New settings are staged and applied only at PWM period boundaries.
module rgb_pwm_fader #(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 188,
  parameter int BLINK_LOG2 = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load,
  input  logic [2*CHANNELS-1:0]        i_mode,
  input  logic [PWM_BITS*CHANNELS-1:0] i_level,
  output logic [CHANNELS-1:0]          o_led,
  output logic                         o_period
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int MW = 2 * CHANNELS;
  localparam int LW = PWM_BITS * CHANNELS;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] M_STATIC  = 2'd1;
  localparam logic [1:0] M_BREATHE = 2'd2;
  localparam logic [1:0] M_BLINK   = 2'd3;

  typedef enum logic {RISE, FALL} bst_t;

  logic [PW-1:0]         presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_LOG2-1:0] blk_cnt;
  logic                  blk_on;
  logic [MW-1:0]         pend_mode, act_mode, eff_mode;
  logic [LW-1:0]         pend_level, act_level, eff_level;
  logic                  pend_flag;
  logic                  tick, boundary, xfer;
  logic [CHANNELS-1:0]   led_d;

  logic [PWM_BITS-1:0] ramp    [CHANNELS];
  logic [PWM_BITS-1:0] ramp_nx [CHANNELS];
  bst_t                st      [CHANNELS];
  bst_t                st_nx   [CHANNELS];

  assign tick     = (presc == PRE_MAX);
  assign boundary = tick && (pwm_cnt == '1);
  assign xfer     = boundary && pend_flag;

  // Settings that will be active in the period starting after this cycle
  assign eff_mode  = xfer ? pend_mode  : act_mode;
  assign eff_level = xfer ? pend_level : act_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc      <= '0;
      pwm_cnt    <= '0;
      blk_cnt    <= '0;
      blk_on     <= 1'b1;
      pend_mode  <= '0;
      pend_level <= '0;
      pend_flag  <= 1'b0;
      act_mode   <= '0;
      act_level  <= '0;
      o_led      <= '0;
      o_period   <= 1'b0;
    end else begin
      presc    <= tick ? '0 : presc + 1'b1;
      o_period <= boundary;
      o_led    <= led_d;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (boundary) begin
        blk_cnt <= blk_cnt + 1'b1;
        if (blk_cnt == '1) blk_on <= ~blk_on;
      end
      // A load on the boundary cycle stays pending for the next period
      if (i_load) begin
        pend_mode  <= i_mode;
        pend_level <= i_level;
        pend_flag  <= 1'b1;
      end else if (xfer) begin
        pend_flag  <= 1'b0;
      end
      if (xfer) begin
        act_mode  <= pend_mode;
        act_level <= pend_level;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ramp[c] <= '0;
        st[c]   <= RISE;
      end
    end else if (boundary) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ramp[c] <= ramp_nx[c];
        st[c]   <= st_nx[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      ramp_nx[c] = ramp[c];
      st_nx[c]   = st[c];
      if (eff_mode[2*c +: 2] != M_BREATHE ||
          act_mode[2*c +: 2] != M_BREATHE) begin
        ramp_nx[c] = '0;
        st_nx[c]   = RISE;
      end else if (ramp[c] > eff_level[PWM_BITS*c +: PWM_BITS]) begin
        ramp_nx[c] = eff_level[PWM_BITS*c +: PWM_BITS];
        st_nx[c]   = FALL;
      end else if (st[c] == RISE) begin
        if (ramp[c] < eff_level[PWM_BITS*c +: PWM_BITS]) begin
          ramp_nx[c] = ramp[c] + 1'b1;
        end else begin
          st_nx[c]   = FALL;
          ramp_nx[c] = (ramp[c] == '0) ? '0 : ramp[c] - 1'b1;
        end
      end else begin
        if (ramp[c] != '0) begin
          ramp_nx[c] = ramp[c] - 1'b1;
        end else begin
          st_nx[c]   = RISE;
          ramp_nx[c] = (eff_level[PWM_BITS*c +: PWM_BITS] == '0) ?
                       '0 : ramp[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (act_mode[2*c +: 2])
        M_STATIC:
          led_d[c] = pwm_cnt < act_level[PWM_BITS*c +: PWM_BITS];
        M_BREATHE:
          led_d[c] = pwm_cnt < ramp[c];
        M_BLINK:
          led_d[c] = blk_on &&
                     (pwm_cnt < act_level[PWM_BITS*c +: PWM_BITS]);
        default:
          led_d[c] = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: per-period on-time counts per channel
// compared against a table of expected duties.
module tb_rgb_pwm_fader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [5:0]  mode = '0;
  logic [11:0] level = '0;
  logic [2:0]  led;
  logic        period;

  int n_chk = 0;
  int n_err = 0;

  int   on_cnt [3];
  int   p_cnt;
  logic p_last;

  typedef struct {
    int          ld;
    logic [5:0]  md;
    logic [11:0] lv;
    int          ld2;
    logic [5:0]  md2;
    logic [11:0] lv2;
    int          e0, e1, e2;
  } vec_t;

  typedef struct {
    int e0, e1, e2;
  } exp_t;

  vec_t tbl [25];
  exp_t exp_q [$];

  rgb_pwm_fader #(
    .CHANNELS(3), .PWM_BITS(4), .PRESCALE(2), .BLINK_LOG2(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_load(load),
    .i_mode(mode),
    .i_level(level),
    .o_led(led),
    .o_period(period)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_period(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period && k < 200);
  endtask

  // One 32-cycle PWM period, starting just after an o_period sample
  task automatic run_window(input int ld, input logic [5:0] md,
                            input logic [11:0] lv, input int ld2,
                            input logic [5:0] md2, input logic [11:0] lv2);
    for (int c = 0; c < 3; c++) on_cnt[c] = 0;
    p_cnt  = 0;
    p_last = 1'b0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (n == ld) begin
        load = 1'b1; mode = md; level = lv;
      end else if (n == ld2) begin
        load = 1'b1; mode = md2; level = lv2;
      end else begin
        load = 1'b0;
      end
      for (int c = 0; c < 3; c++) if (led[c]) on_cnt[c]++;
      if (period) p_cnt++;
      if (n == 32) p_last = period;
    end
    load = 1'b0;
  endtask

  initial begin
    int   k;
    exp_t e;

    tbl[0]  = '{4, 6'b000101, 12'h008, 0, 6'b0, 12'h0, 0, 0, 0};
    tbl[1]  = '{4, 6'b100101, 12'h3F8, 0, 6'b0, 12'h0, 16, 0, 0};
    tbl[2]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 0};
    tbl[3]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 2};
    tbl[4]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 4};
    tbl[5]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 6};
    tbl[6]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 4};
    tbl[7]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 2};
    tbl[8]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 0};
    tbl[9]  = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 2};
    tbl[10] = '{4, 6'b100101, 12'h1F8, 0, 6'b0, 12'h0, 16, 30, 4};
    tbl[11] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 2};
    tbl[12] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 0};
    tbl[13] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 30, 2};
    tbl[14] = '{4, 6'b000000, 12'h000, 0, 6'b0, 12'h0, 16, 30, 0};
    tbl[15] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 0, 0, 0};
    tbl[16] = '{4, 6'b000001, 12'h008, 31, 6'b000001, 12'h004, 0, 0, 0};
    tbl[17] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 16, 0, 0};
    tbl[18] = '{4, 6'b000011, 12'h00F, 0, 6'b0, 12'h0, 8, 0, 0};
    tbl[19] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 30, 0, 0};
    tbl[20] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 30, 0, 0};
    tbl[21] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 0, 0, 0};
    tbl[22] = '{4, 6'b100000, 12'h300, 0, 6'b0, 12'h0, 0, 0, 0};
    tbl[23] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 0, 0, 0};
    tbl[24] = '{0, 6'b0, 12'h0, 0, 6'b0, 12'h0, 0, 0, 2};

    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_period", int'(period), 0);
    rst = 1'b0;
    wait_period(k);
    check("first_period_delay", k, 32);

    for (int i = 0; i < 25; i++) begin
      exp_q.push_back('{tbl[i].e0, tbl[i].e1, tbl[i].e2});
      run_window(tbl[i].ld, tbl[i].md, tbl[i].lv,
                 tbl[i].ld2, tbl[i].md2, tbl[i].lv2);
      e = exp_q.pop_front();
      check($sformatf("w%0d_led0", i + 1), on_cnt[0], e.e0);
      check($sformatf("w%0d_led1", i + 1), on_cnt[1], e.e1);
      check($sformatf("w%0d_led2", i + 1), on_cnt[2], e.e2);
      check($sformatf("w%0d_period", i + 1),
            (p_cnt == 1 && p_last) ? 1 : 0, 1);
    end

    // Reset while ch2 breathes at ramp 2 with a load still pending
    @(negedge clk);
    load = 1'b1; mode = 6'b000001; level = 12'h00F;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("pre_reset_led2", int'(led[2]), 1);
    rst = 1'b1;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_period", int'(period), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_period(k);
    check("post_reset_period_delay", k, 32);

    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{0, 0, 0});
      run_window(0, 6'b0, 12'h0, 0, 6'b0, 12'h0);
      e = exp_q.pop_front();
      check($sformatf("post_rst%0d_led0", i), on_cnt[0], e.e0);
      check($sformatf("post_rst%0d_led1", i), on_cnt[1], e.e1);
      check($sformatf("post_rst%0d_led2", i), on_cnt[2], e.e2);
      check($sformatf("post_rst%0d_period", i),
            (p_cnt == 1 && p_last) ? 1 : 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent LED channels (1..8).
REQ-002 Parameter PWM_BITS, default 8: duty/level resolution; PWM period = 2^PWM_BITS ticks.
REQ-003 Parameter PRESCALE, default 188: i_clk cycles per PWM tick (>=1).
REQ-004 Parameter BLINK_LOG2, default 6: blink half-period = 2^BLINK_LOG2 PWM periods.
REQ-005 i_clk  in  1  single system clock; all state on its rising edge.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_load  in  1  one-cycle strobe; captures i_mode/i_level into pending registers.
REQ-008 i_mode  in  2*CHANNELS  per-channel mode: 0 off, 1 static, 2 breathe, 3 blink.
REQ-009 i_level  in  PWM_BITS*CHANNELS  per-channel duty (static/blink) or peak (breathe).
REQ-010 o_led  out  CHANNELS  registered PWM output per channel, 1 = LED on.
REQ-011 o_period  out  1  one-cycle pulse at each PWM period boundary.

Function
REQ-012 Prescaler counts 0..PRESCALE-1; tick when count = PRESCALE-1, count wraps to 0 same cycle.
REQ-013 PWM counter increments on tick only; wraps 2^PWM_BITS-1 -> 0; boundary = tick while counter = 2^PWM_BITS-1.
REQ-014 o_period SHALL be high the cycle after a boundary, exactly one cycle.
REQ-015 i_load SHALL copy i_mode/i_level into pending and set pending flag; repeated loads overwrite pending.
REQ-016 At a boundary with pending flag set, active mode/level <= pending, flag cleared; active never changes mid-period.
REQ-017 i_load coincident with boundary: boundary transfers old pending; new value stays pending, flag remains set, applied next boundary.
REQ-018 Duty per channel: off -> 0; static -> level; breathe -> ramp r; blink -> level when blink phase ON, else 0.
REQ-019 o_led[c] registered: 1 iff PWM counter < duty, evaluated one cycle after counter update; duty 0 -> never on; duty 2^PWM_BITS-1 -> on 2^PWM_BITS-1 of 2^PWM_BITS ticks.
REQ-020 Breathe FSM per channel, states RISE/FALL, ramp r width PWM_BITS, updated at boundaries only.
REQ-021 RISE: r < level -> r+1; r = level -> FALL, r-1 (or stay 0 if level 0).
REQ-022 FALL: r > 0 -> r-1; r = 0 -> RISE, r+1 (or stay 0 if level 0); r never exceeds level, no wrap.
REQ-023 New active level below current r while breathing: r clamps to level at that boundary, state FALL.
REQ-024 Channel entering breathe from other mode: r = 0, state RISE at activation boundary.
REQ-025 Mode off or static: r held 0, state RISE.
REQ-026 Blink phase counter (BLINK_LOG2 bits, shared) increments per boundary; phase toggles on wrap; phase starts ON after reset.
REQ-027 Channels independent; CHANNELS=1 legal; field c of i_mode/i_level at bits [2c+1:2c] / [PWM_BITS*(c+1)-1:PWM_BITS*c].

Reset
REQ-028 i_rst high SHALL immediately clear prescaler, PWM counter, blink counter, pending and active registers, pending flag, all ramps; states RISE; o_led = 0, o_period = 0.
REQ-029 Reset mid-operation discards pending loads; after release, first boundary occurs 2^PWM_BITS*PRESCALE cycles later.

Verification (CHANNELS=3, PWM_BITS=4, PRESCALE=2, BLINK_LOG2=1)
REQ-030 Load ch0 static level 8, others off -> after next boundary o_led[0] high 16 cycles, low 16 per 32-cycle period; o_led[2:1] = 0.
REQ-031 Load ch1 static 0, then 15 -> 0 on all period; after next boundary on 30 of 32 cycles.
REQ-032 Load ch2 breathe level 3 -> successive per-period duties 0,1,2,3,2,1,0,1...
REQ-033 i_load pulsed on boundary cycle with new level 4 over pending 8 -> 8 applied at that boundary, 4 at the following.
REQ-034 Ch0 blink level 15 -> on 30/32 cycles for 2 periods, dark 2 periods, repeat; o_period pulses every 32 cycles.
REQ-035 Assert i_rst mid-period while breathing -> outputs 0 asynchronously; pending discarded; first o_period 32 cycles after release.
